// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_e;

    // Requester identity; also the encoding of the last_grant register.
    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DMA  = 1'b1
    } req_e;

    // Every access is one naturally aligned doubleword.
    localparam int unsigned XFER_BYTES = 8;
    localparam logic [3:0]  XFER_SIZE  = 4'(XFER_BYTES);

    // The requester that did not win last time.
    function automatic req_e other_req(input req_e r);
        return (r == REQ_CORE) ? REQ_DMA : REQ_CORE;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic: fixed CORE priority or round-robin on ties.
module rr_arb2 import dmem_arb_pkg::*; #(
    parameter bit CORE_PRIO = 1'b1
) (
    input  logic clk,
    input  logic reset,        // asynchronous, active-low
    input  logic core_valid,
    input  logic dma_valid,
    input  logic accept,       // grant is being taken this cycle
    output logic grant_valid,
    output req_e grant_id
);

    req_e last_grant_q;
    req_e last_grant_d;

    // Combinational grant from the current valids and the last winner.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block leaves it unassigned (which would infer a latch).
        grant_valid = core_valid | dma_valid;
        grant_id    = REQ_CORE;
        if (core_valid && dma_valid) begin
            grant_id = CORE_PRIO ? REQ_CORE : other_req(last_grant_q);
        end else if (dma_valid) begin
            grant_id = REQ_DMA;
        end
    end

    // Remember the winner only when the grant is actually consumed.
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant_id;
        end
    end

    // last_grant starts at DMA so CORE wins the first round-robin tie.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: flop state uses non-blocking assignment so every register samples pre-edge values regardless of statement order.
        if (!reset) begin
            last_grant_q <= REQ_DMA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CORE and DMA ports:
// one request in flight, registered memory enables, one response pulse each.
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned RD_LAT    = 1,
    parameter bit          CORE_PRIO = 1'b1
) (
    input  logic              clk,
    input  logic              reset,            // asynchronous, active-low

    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic              core_req_write,
    input  logic [ADDR_W-1:0] core_req_addr,
    input  logic [DATA_W-1:0] core_req_wdata,
    output logic              core_rsp_valid,
    output logic [DATA_W-1:0] core_rsp_rdata,

    input  logic              dma_req_valid,
    output logic              dma_req_ready,
    input  logic              dma_req_write,
    input  logic [ADDR_W-1:0] dma_req_addr,
    input  logic [DATA_W-1:0] dma_req_wdata,
    output logic              dma_rsp_valid,
    output logic [DATA_W-1:0] dma_rsp_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [3:0]        mem_xfer_size,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int unsigned       CNT_W      = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(XFER_BYTES - 1);

    // Sequencer state and latched request.
    state_e              state_q,  state_d;
    logic                write_q,  write_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    req_e                owner_q,  owner_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;

    // Registered outputs.
    logic                mem_re_q, mem_re_d;
    logic                mem_we_q, mem_we_d;
    logic                core_rsp_valid_q, core_rsp_valid_d;
    logic                dma_rsp_valid_q,  dma_rsp_valid_d;
    logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0]   dma_rdata_q,  dma_rdata_d;

    // Grant and handshake.
    logic                grant_valid;
    req_e                grant_id;
    logic                idle_open;
    logic                accept;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_arb2 #(
        .CORE_PRIO (CORE_PRIO)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .core_valid  (core_req_valid),
        .dma_valid   (dma_req_valid),
        .accept      (accept),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Ready is gated by reset too, so every output reads 0 while reset is held.
    assign idle_open      = (state_q == IDLE) && reset;
    assign core_req_ready = idle_open && grant_valid && (grant_id == REQ_CORE);
    assign dma_req_ready  = idle_open && grant_valid && (grant_id == REQ_DMA);
    assign accept         = idle_open && grant_valid;

    assign sel_write = (grant_id == REQ_CORE) ? core_req_write : dma_req_write;
    assign sel_addr  = (grant_id == REQ_CORE) ? core_req_addr  : dma_req_addr;
    assign sel_wdata = (grant_id == REQ_CORE) ? core_req_wdata : dma_req_wdata;

    assign mem_address      = addr_q;
    assign mem_write_data   = wdata_q;
    assign mem_read_enable  = mem_re_q;
    assign mem_write_enable = mem_we_q;
    assign mem_xfer_size    = XFER_SIZE;
    assign core_rsp_valid   = core_rsp_valid_q;
    assign core_rsp_rdata   = core_rdata_q;
    assign dma_rsp_valid    = dma_rsp_valid_q;
    assign dma_rsp_rdata    = dma_rdata_q;

    // Next state: enables and response pulses are one-cycle, so they default to 0.
    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        owner_d          = owner_q;
        cnt_d            = cnt_q;
        mem_re_d         = 1'b0;
        mem_we_d         = 1'b0;
        core_rsp_valid_d = 1'b0;
        dma_rsp_valid_d  = 1'b0;
        core_rdata_d     = '0;
        dma_rdata_d      = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Enables are set on the handshake edge so they are live during ISSUE.
                    state_d  = ISSUE;
                    write_d  = sel_write;
                    addr_d   = sel_addr & ALIGN_MASK;
                    wdata_d  = sel_wdata;
                    owner_d  = grant_id;
                    mem_we_d = sel_write;
                    mem_re_d = !sel_write;
                end
            end

            ISSUE: begin
                if (write_q) begin
                    // Writes answer immediately with zero data.
                    state_d          = RESP;
                    core_rsp_valid_d = (owner_q == REQ_CORE);
                    dma_rsp_valid_d  = (owner_q == REQ_DMA);
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = RD_WAIT;
                end
            end

            RD_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Read data is valid in this cycle; capture it for the owner only.
                    state_d = RESP;
                    if (owner_q == REQ_CORE) begin
                        core_rsp_valid_d = 1'b1;
                        core_rdata_d     = mem_read_data;
                    end else begin
                        dma_rsp_valid_d  = 1'b1;
                        dma_rdata_d      = mem_read_data;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All sequencer state and registered outputs; reset drops any in-flight request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            write_q          <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            owner_q          <= REQ_CORE;
            cnt_q            <= '0;
            mem_re_q         <= 1'b0;
            mem_we_q         <= 1'b0;
            core_rsp_valid_q <= 1'b0;
            dma_rsp_valid_q  <= 1'b0;
            core_rdata_q     <= '0;
            dma_rdata_q      <= '0;
        end else begin
            state_q          <= state_d;
            write_q          <= write_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            owner_q          <= owner_d;
            cnt_q            <= cnt_d;
            mem_re_q         <= mem_re_d;
            mem_we_q         <= mem_we_d;
            core_rsp_valid_q <= core_rsp_valid_d;
            dma_rsp_valid_q  <= dma_rsp_valid_d;
            core_rdata_q     <= core_rdata_d;
            dma_rdata_q      <= dma_rdata_d;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between two requesters: the core load/store port (CORE) and a DMA/debug port (DMA).
- Accepts one request at a time through a valid/ready handshake, grants by fixed priority or round-robin, and sequences the memory enables.
- Returns one response pulse per request to the originator.
- Sits between P5SCPU/DMA and datamem inside the top level.

Parameters:
- ADDR_W, 64, request/memory address width.
- DATA_W, 64, data width.
- RD_LAT, 1, memory read latency in cycles (>=1); mem_read_data is valid RD_LAT cycles after the read_enable cycle.
- CORE_PRIO, 1, 1 = CORE always wins a tie; 0 = round-robin on ties.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- core_req_valid  in  1  CORE request present
- core_req_ready  out  1  CORE request accepted this cycle
- core_req_write  in  1  1 = store, 0 = load
- core_req_addr  in  ADDR_W  byte address
- core_req_wdata  in  DATA_W  store data
- core_rsp_valid  out  1  one-cycle response pulse to CORE
- core_rsp_rdata  out  DATA_W  load data, meaningful only when core_rsp_valid and the request was a load
- dma_req_valid / dma_req_ready / dma_req_write / dma_req_addr / dma_req_wdata / dma_rsp_valid / dma_rsp_rdata  same as CORE set, for DMA
- mem_address  out  ADDR_W  to datamem, with [2:0] forced to 0
- mem_read_enable  out  1  to datamem
- mem_write_enable  out  1  to datamem
- mem_write_data  out  DATA_W  to datamem
- mem_xfer_size  out  4  constant 4'd8
- mem_read_data  in  DATA_W  from datamem

Behaviour:
- FSM states: IDLE, ISSUE, RD_WAIT, RESP.
- IDLE:
  - Grant is combinational from the valids. Only one valid: that requester. Both valid: CORE if CORE_PRIO=1, else the requester not granted last (last_grant register).
  - Only the granted requester sees ready=1. Ready is 0 in every other state.
  - On handshake (valid&&ready): latch write, addr, wdata and requester id; update last_grant; go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_address = {addr[ADDR_W-1:3], 3'b0}.
  - mem_write_enable = write; mem_read_enable = !write; mem_write_data = latched wdata.
  - Write: go to RESP. Read: load latency counter with RD_LAT, go to RD_WAIT.
- RD_WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture mem_read_data into the response register on that edge and go to RESP.
- RESP (one cycle): pulse rsp_valid of the latched requester; rdata holds captured data (reads) or 0 (writes); go to IDLE.
- Latency from handshake cycle T:
  - Write: mem_write_enable at T+1, rsp at T+2.
  - Read: read_enable at T+1, data sampled at T+1+RD_LAT, rsp at T+2+RD_LAT.
  - Next handshake is possible at T+3 (write) or T+3+RD_LAT (read).
- Timing/handshake rules:
  - Responses have no back-pressure; requesters must accept them.
  - Requesters must hold valid and fields stable until ready.
  - Withdrawing valid before ready is tolerated: no grant, no state change.
- Enable rules: mem enables are 0 outside ISSUE; read and write enables are never both 1. mem_address and mem_write_data hold their latched values outside ISSUE.
- Misaligned addresses are silently aligned down. No error signalling.
- Reset (reset=0, any state, including mid-read or mid-write):
  - State goes to IDLE; in-flight request is dropped and no response is issued.
  - All outputs go to 0 except mem_xfer_size.
  - last_grant resets to DMA, so CORE wins the first round-robin tie.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, ISSUE, RD_WAIT, RESP}
  - requester enum {REQ_CORE, REQ_DMA}
  - XFER_BYTES = 8
- One sub-module, rr_arb2: 2-way grant logic with the CORE_PRIO parameter and the last_grant register, so the top stays FSM plus datapath.

Test Plan:
- CORE store addr 0x40, wdata 0xDEADBEEF_CAFEF00D, DMA idle -> core_req_ready=1 at T; at T+1 mem_write_enable=1, mem_address=0x40, mem_write_data matches; core_rsp_valid at T+2 only.
- CORE load 0x40 after that store, RD_LAT=1 -> mem_read_enable at T+1; core_rsp_valid at T+3 with rdata 0xDEADBEEF_CAFEF00D; dma_rsp_valid stays 0.
- Both valid every cycle, CORE_PRIO=0, 4 writes each -> grants strictly alternate CORE, DMA, CORE, ... and the first grant is CORE. With CORE_PRIO=1, all 4 CORE writes complete before any DMA grant.
- DMA load addr 0x47, RD_LAT=3 -> mem_address=0x40; rsp at T+5; ready stays 0 for both ports from T+1 through T+5.
- reset pulsed low at T+2 of a RD_LAT=3 read -> all outputs 0 immediately; no rsp_valid after release; a new CORE request after release completes normally.
- Back-to-back CORE writes with valid held high -> second handshake at T+3; mem enables are never both 1 in any cycle.
